// File: rtl/seq_detect_pkg.sv
// Shared constants for the x1-x2-x2 sequence detector controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_detect_pkg;

  // State codes as {y2,y1}; y2/y1 go straight to the board LEDs.
  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_GOT_X1   = 2'b10;
  localparam logic [1:0] ST_GOT_X1X2 = 2'b01;
  localparam logic [1:0] ST_DETECT   = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    GOT_X1   = ST_GOT_X1,
    GOT_X1X2 = ST_GOT_X1X2,
    DETECT   = ST_DETECT
  } state_t;

  // Bit positions inside led_pin.
  localparam int LED_Y2      = 0;
  localparam int LED_Y1      = 1;
  localparam int LED_Z       = 7;
  localparam int LED_CNT_LSB = 12;

endpackage

// File: rtl/btn_conditioner.sv
// Turns one raw asynchronous button into a debounced level and a one-cycle press pulse.
// Latency: raw edge -> level after DEBOUNCE_CYCLES+2 edges, press one edge later.
// Backpressure: none; the button cannot be stalled.
//
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   btn_raw   - raw button input (asynchronous, bouncing)
//   level     - debounced button level
//   press     - registered 1-cycle pulse on each 0->1 change of level
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= 2'b00;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync <= {sync[0], btn_raw};
      // Count consecutive cycles the synced value disagrees with the
      // accepted level; any agreement (a bounce back) restarts the count.
      if (sync[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Synchronous x1-x2-x2 detector: conditions S3/S2, arbitrates, runs the FSM, stretches z, counts hits.
// Latency: raw press edge -> led_pin change after exactly DEBOUNCE_CYCLES+4 clk edges.
// Backpressure: none; simultaneous x1/x2 pulses are dropped.
//
// Ports:
//   clk     - system clock (100 MHz)
//   rst     - asynchronous active-high reset
//   btn_3   - raw S3 button (x1)
//   btn_2   - raw S2 button (x2)
//   led_pin - [0]=y2, [1]=y1, [7]=stretched z, [15:12]=detection count, rest 0
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int Z_HOLD_CYCLES   = 50_000_000,
  parameter int CNT_W           = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_3,
  input  logic        btn_2,
  output logic [15:0] led_pin
);

  localparam int TW = $clog2(Z_HOLD_CYCLES + 1);

  logic lvl_3, lvl_2;
  logic p1, p2;
  logic unused_lvl;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_x1 (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_3),
    .level   (lvl_3),
    .press   (p1)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_x2 (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_2),
    .level   (lvl_2),
    .press   (p2)
  );

  // Debounced levels are only needed for the pulse logic inside the conditioners.
  assign unused_lvl = lvl_3 ^ lvl_2;

  state_t           state, state_nxt;
  logic [TW-1:0]    tmr, tmr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             z_q;
  logic             x1_ev, x2_ev, det;

  always_comb begin
    state_nxt = state;
    det       = 1'b0;
    // Coincident pulses cancel each other out.
    x1_ev     = p1 & ~p2;
    x2_ev     = p2 & ~p1;
    if (x1_ev) begin
      state_nxt = GOT_X1;
    end else if (x2_ev) begin
      unique case (state)
        IDLE:     state_nxt = IDLE;
        GOT_X1:   state_nxt = GOT_X1X2;
        GOT_X1X2: begin
          state_nxt = DETECT;
          det       = 1'b1;
        end
        DETECT:   state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end

    // A new detection reloads the hold time rather than extending it.
    if (det) begin
      tmr_nxt = TW'(Z_HOLD_CYCLES);
    end else if (tmr != '0) begin
      tmr_nxt = tmr - TW'(1);
    end else begin
      tmr_nxt = tmr;
    end

    cnt_nxt = det ? cnt + CNT_W'(1) : cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tmr   <= '0;
      cnt   <= '0;
      z_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      cnt   <= cnt_nxt;
      // Registered so z rises on the same edge as the DETECT state code.
      z_q   <= (tmr_nxt != '0);
    end
  end

  always_comb begin
    led_pin                           = '0;
    led_pin[LED_Y2]                   = state[1];
    led_pin[LED_Y1]                   = state[0];
    led_pin[LED_Z]                    = z_q;
    led_pin[LED_CNT_LSB +: CNT_W]     = cnt;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Clocked controller that sequences the x1-x2-x2 pulse-sequence detector on the EGO1 board. It takes the raw S3 (x1) and S2 (x2) buttons and turns each one into a single clean pulse per press.
- It arbitrates simultaneous presses, runs the detector state machine synchronously, stretches the detection output so it is visible, and counts detections.
- It replaces the asynchronous feedback loop from the board top level with registered state that is safe for a real board.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable clk cycles needed to accept a new button level (10 ms at 100 MHz).
- Z_HOLD_CYCLES, 50_000_000, number of cycles the detection LED stays lit after each detection (0.5 s).
- CNT_W, 4, width of the detection counter.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- btn_3  input  1  S3 button, raw and asynchronous; this is the x1 input.
- btn_2  input  1  S2 button, raw and asynchronous; this is the x2 input.
- led_pin  output  16  [0]=y2, [1]=y1 (state code), [7]=stretched z, [15:12]=detection count, all other bits 0.

Behaviour:
- Reset: all registers clear asynchronously while rst=1. This covers state=IDLE, the debounced levels, the pulses, the z timer and the counter, so led_pin=16'h0000. Reset asserted mid-sequence discards any partial sequence.
- Button conditioning, per button:
  - 2-flop synchroniser.
  - The debounced level updates only after the synced value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - press pulse = 1 cycle, registered, on a 0->1 change of the debounced level.
  - Holding a button gives exactly one pulse. Release gives no pulse.
- Arbitration:
  - p1 alone is an x1 event; p2 alone is an x2 event.
  - p1 and p2 in the same cycle are both dropped: no state change, no count.
- State encoding {y2,y1}: IDLE=00, GOT_X1=10, GOT_X1X2=01, DETECT=11.
- Transitions:
  - On an x1 event, any state goes to GOT_X1.
  - On an x2 event: IDLE->IDLE, GOT_X1->GOT_X1X2, GOT_X1X2->DETECT, DETECT->IDLE.
  - With no event, the state holds.
- Detection (entering DETECT):
  - The z timer loads Z_HOLD_CYCLES on the same edge the state is written.
  - led_pin[7]=1 while timer != 0. The timer decrements once per cycle.
  - A new detection during the hold reloads the timer; it does not add to it.
  - The counter increments by 1 per DETECT entry and wraps modulo 2^CNT_W (15 -> 0).
- Latency:
  - Raw press edge to state LED change: exactly DEBOUNCE_CYCLES+4 clk edges, made up of 2 sync, the debounce count, 1 pulse register and 1 state register.
  - led_pin[7] and the counter change on the same edge as the state LEDs.
- Overlap: after DETECT, an x1 event restarts the sequence at GOT_X1, so x1,x2,x2,x1,x2,x2 gives 2 detections.
- Outputs are driven directly from registers; there is no combinational path from the buttons to led_pin.

Decomposition:
- Shared package seq_detect_pkg holds:
  - the state encoding localparams (ST_IDLE=2'b00, ST_GOT_X1=2'b10, ST_GOT_X1X2=2'b01, ST_DETECT=2'b11);
  - LED bit index constants (LED_Y2=0, LED_Y1=1, LED_Z=7, LED_CNT_LSB=12).
- Sub-module btn_conditioner (parameter DEBOUNCE_CYCLES; ports clk, rst, btn_raw, level, press) holds the synchroniser, the debounce counter and the edge pulse. It is instantiated twice.
- The FSM, the arbitration, the z timer and the counter stay in seq_detect_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, Z_HOLD_CYCLES=8):
- Clean x1, x2, x2 presses, each held 10 cycles and separated by 10 cycles:
  - led_pin[1:0] shows 2'b01, then 2'b10, then 2'b11 ({y1,y2}), each change DEBOUNCE_CYCLES+4 edges after its press.
  - led_pin[7] is high for exactly 8 cycles; led_pin[15:12] = 1.
- btn_3 toggled every 2 cycles for 20 cycles, then held high: exactly one x1 event, state = GOT_X1, no extra transitions.
- btn_3 and btn_2 pressed on the same cycle, from GOT_X1: both pulses coincide, state stays 10, count unchanged, led_pin[7]=0.
- Sequence x1, x2, x2 repeated 17 times: 17 detections, counter ends at 1 (wrap), led_pin[7] reloaded on each detection.
- Partial sequence x1, x2 (state 01), then x1 pulse: state goes to GOT_X1 and a following x2, x2 yields one detection.
- rst pulsed for 1 cycle asynchronously while in GOT_X1X2 with z timer = 5:
  - led_pin goes to 0 immediately, without waiting for clk.
  - After release, a lone x2 press leaves state at IDLE.
